// File: rtl/cursor_pos_ctrl.sv
// Frame-synchronous sprite position controller: button motion once per frame, CPU absolute writes, atomic X/Y commit.
// Optional build macro CURSOR_WRAP_EN: button motion wraps around the visible area instead of saturating.
module cursor_pos_ctrl #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int SPRITE_W = 50,
    parameter int SPRITE_H = 50,
    parameter int STEP     = 1,
    parameter int INIT_X   = 50,
    parameter int INIT_Y   = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        screenEnd,
    input  logic        BTNU,
    input  logic        BTND,
    input  logic        BTNL,
    input  logic        BTNR,
    input  logic        cpu_wr_req,
    input  logic [9:0]  cpu_wr_x,
    input  logic [8:0]  cpu_wr_y,
    output logic        cpu_wr_ack,
    output logic [9:0]  box_x,
    output logic [8:0]  box_y,
    output logic        busy,
    output logic [15:0] frame_count
);

    localparam logic signed [10:0] X_MAX  = 11'(SCREEN_W - SPRITE_W);
    localparam logic signed [10:0] Y_MAX  = 11'(SCREEN_H - SPRITE_H);
    localparam logic signed [10:0] STEP_S = 11'(STEP);

    typedef enum logic [2:0] {IDLE, CALC, BOUND, WBOUND, COMMIT} state_t;

    state_t state, next_state;

    logic [3:0]         btn_meta, btn_sync, btn_snap;
    logic               screen_end_d;
    logic               frame_edge;
    logic               pending_frame;
    logic               src_cpu;
    logic signed [10:0] sx, sy;
    logic signed [10:0] dx, dy;
    logic signed [10:0] sx_calc, sy_calc;
    logic signed [10:0] sx_bound, sy_bound;
    logic signed [10:0] wx, wy;

    assign frame_edge = screenEnd & ~screen_end_d;
    assign busy       = (state != IDLE);
    assign cpu_wr_ack = (state == COMMIT) && src_cpu;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (frame_edge || pending_frame)
                    next_state = CALC;
                else if (cpu_wr_req)
                    next_state = WBOUND;
            end
            CALC:    next_state = BOUND;
            BOUND:   next_state = COMMIT;
            WBOUND:  next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Snapshot bit order is {U, D, L, R}; opposing presses cancel.
    always_comb begin
        dx = '0;
        dy = '0;
        if (btn_snap[0] && !btn_snap[1])
            dx = STEP_S;
        else if (btn_snap[1] && !btn_snap[0])
            dx = -STEP_S;
        if (btn_snap[2] && !btn_snap[3])
            dy = STEP_S;
        else if (btn_snap[3] && !btn_snap[2])
            dy = -STEP_S;
        sx_calc = $signed({1'b0, box_x}) + dx;
        sy_calc = $signed({2'b00, box_y}) + dy;
    end

    always_comb begin
        sx_bound = sx;
        sy_bound = sy;
`ifdef CURSOR_WRAP_EN
        if (sx < 0)
            sx_bound = sx + X_MAX + 11'sd1;
        else if (sx > X_MAX)
            sx_bound = sx - X_MAX - 11'sd1;
        if (sy < 0)
            sy_bound = sy + Y_MAX + 11'sd1;
        else if (sy > Y_MAX)
            sy_bound = sy - Y_MAX - 11'sd1;
`else
        if (sx < 0)
            sx_bound = '0;
        else if (sx > X_MAX)
            sx_bound = X_MAX;
        if (sy < 0)
            sy_bound = '0;
        else if (sy > Y_MAX)
            sy_bound = Y_MAX;
`endif
    end

    // CPU writes always saturate, even in a wrap build.
    always_comb begin
        wx = $signed({1'b0, cpu_wr_x});
        wy = $signed({2'b00, cpu_wr_y});
        if (wx > X_MAX)
            wx = X_MAX;
        if (wy > Y_MAX)
            wy = Y_MAX;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta      <= '0;
            btn_sync      <= '0;
            btn_snap      <= '0;
            screen_end_d  <= 1'b0;
            pending_frame <= 1'b0;
            src_cpu       <= 1'b0;
            sx            <= '0;
            sy            <= '0;
            box_x         <= 10'(INIT_X);
            box_y         <= 9'(INIT_Y);
            frame_count   <= '0;
        end else begin
            btn_meta     <= {BTNU, BTND, BTNL, BTNR};
            btn_sync     <= btn_meta;
            screen_end_d <= screenEnd;

            // Only one missed frame is remembered while the FSM is busy.
            if (state == IDLE) begin
                if (frame_edge || pending_frame) begin
                    pending_frame <= 1'b0;
                    btn_snap      <= btn_sync;
                    src_cpu       <= 1'b0;
                end else if (cpu_wr_req) begin
                    src_cpu <= 1'b1;
                end
            end else if (frame_edge) begin
                pending_frame <= 1'b1;
            end

            case (state)
                CALC: begin
                    sx <= sx_calc;
                    sy <= sy_calc;
                end
                BOUND: begin
                    sx <= sx_bound;
                    sy <= sy_bound;
                end
                WBOUND: begin
                    sx <= wx;
                    sy <= wy;
                end
                COMMIT: begin
                    box_x <= sx[9:0];
                    box_y <= sy[8:0];
                    if (!src_cpu)
                        frame_count <= frame_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cursor_pos_ctrl.sv
// Directed, table-driven bench for cursor_pos_ctrl; expectations follow CURSOR_WRAP_EN when it is defined.
module tb_cursor_pos_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        screenEnd;
    logic        BTNU, BTND, BTNL, BTNR;
    logic        cpu_wr_req;
    logic [9:0]  cpu_wr_x;
    logic [8:0]  cpu_wr_y;
    logic        cpu_wr_ack;
    logic [9:0]  box_x;
    logic [8:0]  box_y;
    logic        busy;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;

`ifdef CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef struct {
        bit          is_cpu;
        logic [3:0]  btn;
        logic [9:0]  wx;
        logic [8:0]  wy;
        logic [9:0]  ex;
        logic [8:0]  ey;
        logic [15:0] efc;
        string       name;
    } vec_t;

    vec_t vecs[14];

    logic [9:0]  exp_x;
    logic [8:0]  exp_y;
    logic [15:0] exp_fc;

    cursor_pos_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .screenEnd   (screenEnd),
        .BTNU        (BTNU),
        .BTND        (BTND),
        .BTNL        (BTNL),
        .BTNR        (BTNR),
        .cpu_wr_req  (cpu_wr_req),
        .cpu_wr_x    (cpu_wr_x),
        .cpu_wr_y    (cpu_wr_y),
        .cpu_wr_ack  (cpu_wr_ack),
        .box_x       (box_x),
        .box_y       (box_y),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input bit is_cpu, input logic [3:0] btn, input logic [9:0] wx,
                                input logic [8:0] wy, input logic [9:0] ex, input logic [8:0] ey,
                                input logic [15:0] efc, input string name);
        vec_t v;
        v.is_cpu = is_cpu;
        v.btn    = btn;
        v.wx     = wx;
        v.wy     = wy;
        v.ex     = ex;
        v.ey     = ey;
        v.efc    = efc;
        v.name   = name;
        return v;
    endfunction

    // One frame with buttons held: box must stay old through E+3, busy exactly 3 cycles.
    task automatic runFrame(input logic [3:0] btn, input string name);
        int busy_cnt;
        {BTNU, BTND, BTNL, BTNR} = btn;
        repeat (3) tick();
        screenEnd = 1'b1;
        busy_cnt  = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (busy) busy_cnt++;
            if (i == 3) begin
                checkOutput({name, " x before commit"}, 32'(box_x), 32'(exp_x));
                checkOutput({name, " y before commit"}, 32'(box_y), 32'(exp_y));
            end
            if (i == 5) screenEnd = 1'b0;
        end
        checkOutput({name, " busy cycles"}, 32'(busy_cnt), 32'd3);
        {BTNU, BTND, BTNL, BTNR} = 4'b0000;
    endtask

    task automatic runCpu(input logic [9:0] x, input logic [8:0] y, input string name);
        int lat;
        cpu_wr_x   = x;
        cpu_wr_y   = y;
        cpu_wr_req = 1'b1;
        lat        = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (cpu_wr_ack) begin
                lat = i;
                break;
            end
        end
        cpu_wr_req = 1'b0;
        checkOutput({name, " ack latency"}, 32'(lat), 32'd2);
        tick();
        checkOutput({name, " ack single pulse"}, 32'(cpu_wr_ack), 32'd0);
        checkOutput({name, " idle after write"}, 32'(busy), 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.is_cpu)
            runCpu(v.wx, v.wy, v.name);
        else
            runFrame(v.btn, v.name);
        checkOutput({v.name, " box_x"}, 32'(box_x), 32'(v.ex));
        checkOutput({v.name, " box_y"}, 32'(box_y), 32'(v.ey));
        checkOutput({v.name, " frame_count"}, 32'(frame_count), 32'(v.efc));
        exp_x  = v.ex;
        exp_y  = v.ey;
        exp_fc = v.efc;
    endtask

    initial begin
        int busy_cnt;
        int ack_cnt;
        int ack_at;

        reset      = 1'b1;
        screenEnd  = 1'b0;
        {BTNU, BTND, BTNL, BTNR} = 4'b0000;
        cpu_wr_req = 1'b0;
        cpu_wr_x   = '0;
        cpu_wr_y   = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        checkOutput("reset box_x", 32'(box_x), 32'd50);
        checkOutput("reset box_y", 32'(box_y), 32'd50);
        checkOutput("reset frame_count", 32'(frame_count), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset ack", 32'(cpu_wr_ack), 32'd0);
        exp_x  = 10'd50;
        exp_y  = 9'd50;
        exp_fc = 16'd0;

        // Button encoding is {U, D, L, R}.
        vecs[0]  = mk(0, 4'b0001, 0, 0, 51, 50, 1, "right 1");
        vecs[1]  = mk(0, 4'b0001, 0, 0, 52, 50, 2, "right 2");
        vecs[2]  = mk(0, 4'b0001, 0, 0, 53, 50, 3, "right 3");
        vecs[3]  = mk(1, 4'b0000, 0, 0, 0, 0, 3, "cpu origin");
        vecs[4]  = mk(0, 4'b1010, 0, 0, WRAP ? 10'd590 : 10'd0, WRAP ? 9'd430 : 9'd0, 4, "up-left 1");
        vecs[5]  = mk(0, 4'b1010, 0, 0, WRAP ? 10'd589 : 10'd0, WRAP ? 9'd429 : 9'd0, 5, "up-left 2");
        vecs[6]  = mk(1, 4'b0000, 1000, 500, 590, 430, 5, "cpu oversize");
        vecs[7]  = mk(0, 4'b0101, 0, 0, WRAP ? 10'd0 : 10'd590, WRAP ? 9'd0 : 9'd430, 6, "down-right at max");
        vecs[8]  = mk(0, 4'b1111, 0, 0, WRAP ? 10'd0 : 10'd590, WRAP ? 9'd0 : 9'd430, 7, "all buttons");
        vecs[9]  = mk(1, 4'b0000, 100, 200, 100, 200, 7, "cpu mid");
        vecs[10] = mk(0, 4'b0100, 0, 0, 100, 201, 8, "down");
        vecs[11] = mk(0, 4'b0000, 0, 0, 100, 201, 9, "no button");
        vecs[12] = mk(1, 4'b0000, 589, 429, 589, 429, 9, "cpu near max");
        vecs[13] = mk(0, 4'b0101, 0, 0, 590, 430, 10, "down-right to max");

        for (int i = 0; i < 14; i++)
            applyStimulus(vecs[i]);

        // CPU request raised together with the frame edge: buttons first, CPU 3 cycles later.
        BTNL = 1'b1;
        repeat (3) tick();
        cpu_wr_x   = 10'd300;
        cpu_wr_y   = 9'd100;
        cpu_wr_req = 1'b1;
        screenEnd  = 1'b1;
        ack_cnt    = 0;
        ack_at     = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (cpu_wr_ack) begin
                ack_cnt++;
                if (ack_at < 0) ack_at = i;
                cpu_wr_req = 1'b0;
            end
            if (i == 4) begin
                checkOutput("race button x", 32'(box_x), 32'd589);
                checkOutput("race button fc", 32'(frame_count), 32'd11);
            end
            if (i == 7) begin
                checkOutput("race cpu x", 32'(box_x), 32'd300);
                checkOutput("race cpu y", 32'(box_y), 32'd100);
            end
        end
        checkOutput("race ack cycle", 32'(ack_at), 32'd6);
        checkOutput("race ack count", 32'(ack_cnt), 32'd1);
        checkOutput("race final fc", 32'(frame_count), 32'd11);
        cpu_wr_req = 1'b0;
        screenEnd  = 1'b0;
        BTNL       = 1'b0;
        repeat (2) tick();

        // Second frame edge while busy is held and served after the first commit.
        screenEnd = 1'b1;
        busy_cnt  = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            screenEnd = (i == 2);
            if (busy) busy_cnt++;
            if (i == 4) checkOutput("pending first fc", 32'(frame_count), 32'd12);
            if (i == 8) checkOutput("pending second fc", 32'(frame_count), 32'd13);
        end
        checkOutput("pending busy cycles", 32'(busy_cnt), 32'd6);
        checkOutput("pending box_x", 32'(box_x), 32'd300);
        checkOutput("pending box_y", 32'(box_y), 32'd100);

        // Reset during CALC with right held must abort without any commit.
        BTNR = 1'b1;
        repeat (3) tick();
        screenEnd = 1'b1;
        tick();
        checkOutput("abort in calc busy", 32'(busy), 32'd1);
        reset     = 1'b1;
        screenEnd = 1'b0;
        tick();
        checkOutput("abort box_x", 32'(box_x), 32'd50);
        checkOutput("abort box_y", 32'(box_y), 32'd50);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort frame_count", 32'(frame_count), 32'd0);
        checkOutput("abort ack", 32'(cpu_wr_ack), 32'd0);
        reset    = 1'b0;
        busy_cnt = 0;
        ack_cnt  = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (busy) busy_cnt++;
            if (cpu_wr_ack) ack_cnt++;
        end
        checkOutput("post-abort busy cycles", 32'(busy_cnt), 32'd0);
        checkOutput("post-abort acks", 32'(ack_cnt), 32'd0);
        checkOutput("post-abort box_x", 32'(box_x), 32'd50);
        BTNR = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
